sw_input_debounce: RTL

//   Conditions the raw DE2 slide-switch inputs before they reach the processor's io_sw_i port.
//   The processor's memory stage maps io_sw_i as the switch input register.

---
 rtl/sw_input_debounce.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sw_input_debounce.sv
// Slide-switch conditioner: per-bit synchronizer, debounce FSM, edge pulses, sticky change flag.
// Ports: clk_i, rst_ni, sw_raw_i, ack_i -> sw_o, rise_o, fall_o, changed_o (all registered).
module sw_input_debounce #(
  parameter int WIDTH        = 17,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] sw_raw_i,
  input  logic             ack_i,
  output logic [WIDTH-1:0] sw_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             changed_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_COUNT  = 1'b1
  } state_t;

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] w_sync_q;
  logic [WIDTH-1:0] r_sw;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_changed;

  logic [WIDTH-1:0] w_sw_nx;
  logic [WIDTH-1:0] w_rise_nx;
  logic [WIDTH-1:0] w_fall_nx;

  // Plain flop chain: no logic between stages.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '0;
      end
    end else begin
      r_sync[0] <= sw_raw_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign w_sync_q = r_sync[SYNC_STAGES-1];

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    state_t           r_st;
    state_t           w_st_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             w_mis;
    logic             w_lvl_nx;
    logic             w_rise;
    logic             w_fall;

    assign w_mis = w_sync_q[g] ^ r_sw[g];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_st  <= ST_STABLE;
        r_cnt <= '0;
      end else begin
        r_st  <= w_st_nx;
        r_cnt <= w_cnt_nx;
      end
    end

    always_comb begin
      w_st_nx  = r_st;
      w_cnt_nx = r_cnt;
      w_lvl_nx = r_sw[g];
      w_rise   = 1'b0;
      w_fall   = 1'b0;
      unique case (r_st)
        ST_STABLE: begin
          if (w_mis) begin
            w_st_nx  = ST_COUNT;
            w_cnt_nx = CNT_ONE;
          end else begin
            w_cnt_nx = '0;
          end
        end
        ST_COUNT: begin
          if (!w_mis) begin
            // Bounced back: drop the partial count.
            w_st_nx  = ST_STABLE;
            w_cnt_nx = '0;
          end else if (r_cnt == CNT_TERM) begin
            w_st_nx  = ST_STABLE;
            w_cnt_nx = '0;
            w_lvl_nx = w_sync_q[g];
            w_rise   = w_sync_q[g];
            w_fall   = ~w_sync_q[g];
          end else begin
            w_cnt_nx = r_cnt + CNT_ONE;
          end
        end
        default: begin
          w_st_nx  = ST_STABLE;
          w_cnt_nx = '0;
        end
      endcase
    end

    assign w_sw_nx[g]   = w_lvl_nx;
    assign w_rise_nx[g] = w_rise;
    assign w_fall_nx[g] = w_fall;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sw   <= '0;
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_sw   <= w_sw_nx;
      r_rise <= w_rise_nx;
      r_fall <= w_fall_nx;
    end
  end

  // Set wins over ack so an event coinciding with ack is not lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_changed <= 1'b0;
    end else if (|(r_rise | r_fall)) begin
      r_changed <= 1'b1;
    end else if (ack_i) begin
      r_changed <= 1'b0;
    end
  end

  assign sw_o      = r_sw;
  assign rise_o    = r_rise;
  assign fall_o    = r_fall;
  assign changed_o = r_changed;

endmodule
